encrypter_feeder: RTL and testbench

//  Upstream feeder for the Encrypter stage. Buffers plaintext words in a FIFO and loads the key

---
 rtl/encrypter_feeder.sv | 149 ++++++++++++++
 tb/tb_encrypter_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypter_feeder.sv
// Feeder for the Encrypter stage: plaintext FIFO, key programming path
// and the reqIn/rdyIn word handshake with a rolling rotation offset.
module encrypter_feeder #(
  parameter int DATA_W   = 32,
  parameter int ROT_W    = 5,
  parameter int DEPTH    = 8,
  parameter int ROT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        key_in,
  input  logic                     key_load,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DATA_W-1:0]        enc_dataIn,
  output logic [ROT_W-1:0]         enc_rot_offset,
  output logic                     enc_prog,
  output logic                     enc_rdyIn,
  input  logic                     enc_reqIn,
  output logic                     keyed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      C_CNT1 = (AW+1)'(1);
  localparam logic [AW-1:0]    C_PTR1 = AW'(1);
  localparam logic [ROT_W-1:0] C_STEP = ROT_W'(ROT_STEP);

  typedef enum logic [2:0] {
    IDLE, KEY_PROG, KEY_HOLD, WAIT_REQ, ISSUE, HOLD
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic [DATA_W-1:0] r_key;
  logic              r_pend;
  logic              r_keyed;
  logic [ROT_W-1:0]  r_offset;
  logic [DATA_W-1:0] r_data;
  logic [ROT_W-1:0]  r_rot;
  logic              r_prog;
  logic              r_rdy;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = wr_en && !w_full;
  // A pending key always wins over issuing the next word
  assign w_pop   = (r_state == WAIT_REQ) && !r_pend
                && enc_reqIn && !w_empty;

  assign full           = w_full;
  assign empty          = w_empty;
  assign count          = r_count;
  assign overflow       = r_ovf;
  assign enc_dataIn     = r_data;
  assign enc_rot_offset = r_rot;
  assign enc_prog       = r_prog;
  assign enc_rdyIn      = r_rdy;
  assign keyed          = r_keyed;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_PTR1;
      if (w_pop)  r_rptr <= r_rptr + C_PTR1;
      if (wr_en && w_full) r_ovf <= 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT1;
        2'b01:   r_count <= r_count - C_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_key    <= '0;
      r_pend   <= 1'b0;
      r_keyed  <= 1'b0;
      r_offset <= '0;
      r_data   <= '0;
      r_rot    <= '0;
      r_prog   <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_prog <= 1'b0;
      r_rdy  <= 1'b0;
      if (key_load) begin
        r_key  <= key_in;
        r_pend <= 1'b1;
      end
      unique case (r_state)
        IDLE, WAIT_REQ: begin
          if (r_pend) begin
            r_data   <= r_key;
            r_prog   <= 1'b1;
            r_offset <= '0;
            // a key_load landing now re-arms the request
            r_pend   <= key_load;
            r_state  <= KEY_PROG;
          end else if (w_pop) begin
            r_data  <= r_mem[r_rptr];
            r_rot   <= r_offset;
            r_rdy   <= 1'b1;
            r_state <= ISSUE;
          end
        end
        KEY_PROG: r_state <= KEY_HOLD;
        KEY_HOLD: begin
          if (enc_reqIn) begin
            r_keyed <= 1'b1;
            r_state <= WAIT_REQ;
          end
        end
        ISSUE: r_state <= HOLD;
        HOLD: begin
          if (!enc_reqIn) begin
            r_offset <= r_offset + C_STEP;
            r_state  <= WAIT_REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypter_feeder.sv
// Directed bench for encrypter_feeder: key load, word issue, offsets,
// offset wrap, FIFO full/overflow, key mid-transfer and async reset.
module tb_encrypter_feeder;

  logic        clk;
  logic        reset;
  logic [31:0] key_in;
  logic        key_load;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic [31:0] enc_dataIn;
  logic [4:0]  enc_rot_offset;
  logic        enc_prog;
  logic        enc_rdyIn;
  logic        enc_reqIn;
  logic        keyed;

  int n_checks = 0;
  int n_fail   = 0;

  encrypter_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .key_in         (key_in),
    .key_load       (key_load),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .enc_dataIn     (enc_dataIn),
    .enc_rot_offset (enc_rot_offset),
    .enc_prog       (enc_prog),
    .enc_rdyIn      (enc_rdyIn),
    .enc_reqIn      (enc_reqIn),
    .keyed          (keyed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encrypter model: raise reqIn, wait for rdyIn, sample, drop reqIn
  task automatic recv(input string tag,
                      output logic [31:0] d,
                      output logic [4:0] off);
    bit got;
    got = 0;
    d = '0;
    off = '0;
    enc_reqIn = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (enc_rdyIn === 1'b1) got = 1;
    end
    chk({tag, "_rdy_seen"}, 64'(got), 64'd1);
    if (got) begin
      d   = enc_dataIn;
      off = enc_rot_offset;
      chk({tag, "_no_overlap"}, 64'(enc_prog), 64'd0);
    end
    enc_reqIn = 1'b0;
    tick();
    tick();
  endtask

  task automatic push(input logic [31:0] w);
    wr_data = w;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  off;
    int          seen;

    reset     = 1'b1;
    key_in    = '0;
    key_load  = 1'b0;
    wr_data   = '0;
    wr_en     = 1'b0;
    enc_reqIn = 1'b0;
    tick();
    tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_outs", {enc_dataIn, 27'(enc_rot_offset), enc_prog,
        enc_rdyIn, keyed, full, overflow}, 64'd0);
    reset = 1'b0;

    // T1 key then data
    load_key(32'hA5A5_0F0F);
    tick();
    chk("t1_prog", 64'(enc_prog), 64'd1);
    chk("t1_prog_data", 64'(enc_dataIn), 64'hA5A5_0F0F);
    chk("t1_prog_rdy", 64'(enc_rdyIn), 64'd0);
    enc_reqIn = 1'b1;
    tick();
    chk("t1_prog_pulse", 64'(enc_prog), 64'd0);
    chk("t1_keyhold_data", 64'(enc_dataIn), 64'hA5A5_0F0F);
    chk("t1_not_keyed", 64'(keyed), 64'd0);
    tick();
    chk("t1_keyed", 64'(keyed), 64'd1);
    push(32'h1234_5678);
    chk("t1_count1", 64'(count), 64'd1);
    chk("t1_no_rdy_yet", 64'(enc_rdyIn), 64'd0);
    tick();
    chk("t1_rdy", 64'(enc_rdyIn), 64'd1);
    chk("t1_data", 64'(enc_dataIn), 64'h1234_5678);
    chk("t1_off", 64'(enc_rot_offset), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);
    enc_reqIn = 1'b0;
    tick();
    chk("t1_rdy_pulse", 64'(enc_rdyIn), 64'd0);
    chk("t1_data_hold", 64'(enc_dataIn), 64'h1234_5678);
    tick();

    // T2 offsets 0..3 after a fresh key, FIFO order kept
    for (int i = 0; i < 4; i++) push(32'hAAAA_0001 + 32'(i));
    chk("t2_count4", 64'(count), 64'd4);
    load_key(32'h0BAD_F00D);
    tick();
    chk("t2_prog", 64'(enc_prog), 64'd1);
    chk("t2_prog_data", 64'(enc_dataIn), 64'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      recv("t2", d, off);
      chk("t2_data", 64'(d), 64'(32'hAAAA_0001 + 32'(i)));
      chk("t2_off", 64'(off), 64'(i));
    end

    // T3 offset wraps after 32 words
    load_key(32'h1111_2222);
    for (int i = 0; i < 33; i++) begin
      push(32'hB000_0000 + 32'(i));
      recv("t3", d, off);
      chk("t3_data", 64'(d), 64'(32'hB000_0000 + 32'(i)));
      chk("t3_off", 64'(off), 64'(i % 32));
    end

    // T4 full and overflow, 9th word dropped
    chk("t4_ovf_clear", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i));
    chk("t4_full8", 64'(full), 64'd1);
    chk("t4_count8", 64'(count), 64'd8);
    chk("t4_ovf_before", 64'(overflow), 64'd0);
    push(32'hC8);
    chk("t4_full9", 64'(full), 64'd1);
    chk("t4_count9", 64'(count), 64'd8);
    chk("t4_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      recv("t4", d, off);
      chk("t4_data", 64'(d), 64'(32'hC0 + 32'(i)));
      chk("t4_off", 64'(off), 64'(1 + i));
    end
    chk("t4_empty", 64'(empty), 64'd1);
    seen = 0;
    enc_reqIn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (enc_rdyIn) seen++;
    end
    enc_reqIn = 1'b0;
    tick();
    tick();
    chk("t4_9th_not_issued", 64'(seen), 64'd0);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // T5 key_load while a word is held
    push(32'hD1);
    push(32'hD2);
    enc_reqIn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (enc_rdyIn) seen = 1;
    end
    chk("t5_rdy_seen", 64'(seen), 64'd1);
    chk("t5_d1", 64'(enc_dataIn), 64'hD1);
    chk("t5_d1_off", 64'(enc_rot_offset), 64'd9);
    tick();
    load_key(32'h5555_AAAA);
    chk("t5_hold_data", 64'(enc_dataIn), 64'hD1);
    chk("t5_hold_noprog", 64'(enc_prog), 64'd0);
    enc_reqIn = 1'b0;
    tick();
    tick();
    chk("t5_prog", 64'(enc_prog), 64'd1);
    chk("t5_prog_data", 64'(enc_dataIn), 64'h5555_AAAA);
    chk("t5_prog_nordy", 64'(enc_rdyIn), 64'd0);
    recv("t5", d, off);
    chk("t5_d2", 64'(d), 64'hD2);
    chk("t5_d2_off", 64'(off), 64'd0);

    // T6 async reset while in ISSUE
    push(32'hE1);
    enc_reqIn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (enc_rdyIn) seen = 1;
    end
    chk("t6_rdy_seen", 64'(seen), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_outs", {enc_dataIn, 27'(enc_rot_offset), enc_prog,
        enc_rdyIn, keyed, full, overflow}, 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_count", 64'(count), 64'd0);
    tick();
    reset = 1'b0;
    push(32'hE2);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (enc_rdyIn) seen++;
    end
    chk("t6_no_rdy_unkeyed", 64'(seen), 64'd0);
    chk("t6_word_kept", 64'(count), 64'd1);
    load_key(32'h7777_0001);
    recv("t6", d, off);
    chk("t6_data", 64'(d), 64'hE2);
    chk("t6_off", 64'(off), 64'd0);
    chk("t6_keyed", 64'(keyed), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
